tx_fifo_frame_reader: RTL and testbench

- Read side of the 1024x64 TX data FIFO. Pops length-prefixed frames out of the FIFO and presents them to the MAC transmit path as a valid/ready word stream with start-of-packet, end-of-packet and last-word byte count.
- Runs entirely in the FIFO read-clock domain.
- Absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so downstream backpressure never loses a word.

---
 rtl/tx_fifo_frame_reader_if.sv | 38 +++
 rtl/tx_fifo_frame_reader.sv | 193 +++++++++++++++++++
 tb/tb_tx_fifo_frame_reader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_fifo_frame_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo_frame_reader_if
// Description : Bundles the TX FIFO read port and the MAC transmit word
//               stream used by tx_fifo_frame_reader.
//               master : frame reader side (pops FIFO, drives tx stream)
//               slave  : environment side (FIFO + MAC transmit path)
//   fifo_rdempty  FIFO empty flag
//   fifo_q        FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdreq    FIFO pop request
//   tx_rdy        downstream accepts the current word this cycle
//   tx_val/tx_data/tx_sop/tx_eop/tx_mod  transmit word and framing
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_fifo_frame_reader_if #(
  parameter int WIDTH = 64
);
  logic             fifo_rdempty;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_rdreq;
  logic             tx_rdy;
  logic             tx_val;
  logic [WIDTH-1:0] tx_data;
  logic             tx_sop;
  logic             tx_eop;
  logic [2:0]       tx_mod;

  modport master (
    input  fifo_rdempty, fifo_q, tx_rdy,
    output fifo_rdreq, tx_val, tx_data, tx_sop, tx_eop, tx_mod
  );

  modport slave (
    output fifo_rdempty, fifo_q, tx_rdy,
    input  fifo_rdreq, tx_val, tx_data, tx_sop, tx_eop, tx_mod
  );
endinterface
`default_nettype wire

// File: rtl/tx_fifo_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo_frame_reader
// Description : Read side of the TX data FIFO. Pops length-prefixed frames
//               (one header word holding the byte length, then ceil(len/8)
//               data words) and presents them as a valid/ready word stream
//               with sop/eop/mod framing. A 2-entry output buffer absorbs
//               the FIFO's one-cycle read latency.
//   clk      read-side clock (FIFO rdclk)
//   reset_   asynchronous active-low reset
//   bus      FIFO read port + transmit stream (master modport)
//   hdr_err  one-cycle pulse when a header is discarded
//   frm_cnt  frames fully transferred (eop accepted), wraps at 2^32
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo_frame_reader #(
  parameter int WIDTH   = 64,
  parameter int MAX_LEN = 9600,
  parameter int LEN_W   = 14
) (
  input  wire                     clk,
  input  wire                     reset_,
  tx_fifo_frame_reader_if.master  bus,
  output logic                    hdr_err,
  output logic [31:0]             frm_cnt
);

  // Buffer entry layout: {data, sop, eop, mod}
  localparam int               c_EW      = WIDTH + 5;
  localparam int               c_WL_W    = LEN_W - 2;
  localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HDR_WAIT = 2'd1,
    S_DATA     = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_armed;
  logic                r_inflight;
  logic                r_if_data;
  logic                r_if_sop;
  logic                r_if_eop;
  logic [c_WL_W-1:0]   r_words_left;
  logic [2:0]          r_last_mod;
  logic                r_first;
  logic [1:0]          r_occ;
  logic [c_EW-1:0]     r_ent0, r_ent1;

  logic                w_pop, w_push, w_eop_pop;
  logic [1:0]          w_level;
  logic                w_room, w_can_rd;
  logic                w_rdreq, w_data_rd, w_hdr_load, w_hdr_drop;
  logic [LEN_W-1:0]    w_len;
  logic [LEN_W:0]      w_len_sum;
  logic                w_hdr_bad;
  logic [c_EW-1:0]     w_new;

  assign w_pop     = (r_occ != 2'd0) & bus.tx_rdy;
  assign w_eop_pop = w_pop & r_ent0[3];
  assign w_push    = r_if_data;

  // Buffer slots committed after this cycle's pop; counting the pop lets
  // reads stream back to back while the head is drained every cycle.
  assign w_level  = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_room   = (w_level < 2'd2);
  // r_armed keeps rdreq low through reset and the first cycle after release.
  assign w_can_rd = r_armed & ~bus.fifo_rdempty & w_room;

  assign w_len     = bus.fifo_q[LEN_W-1:0];
  assign w_len_sum = {1'b0, w_len} + (LEN_W+1)'(7);
  assign w_hdr_bad = (w_len == '0) | (w_len > c_MAX_LEN);

  assign w_new = {bus.fifo_q, r_if_sop, r_if_eop, (r_if_eop ? r_last_mod : 3'd0)};

  always_comb begin
    w_state_nxt = r_state;
    w_rdreq     = 1'b0;
    w_data_rd   = 1'b0;
    w_hdr_load  = 1'b0;
    w_hdr_drop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_rd) begin
          w_rdreq     = 1'b1;
          w_state_nxt = S_HDR_WAIT;
        end
      end
      S_HDR_WAIT: begin
        if (w_hdr_bad) begin
          w_hdr_drop  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_hdr_load  = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (r_words_left != '0) begin
          if (w_can_rd) begin
            w_rdreq   = 1'b1;
            w_data_rd = 1'b1;
          end
        end else if (w_eop_pop) begin
          // Next header may be fetched in the same cycle eop leaves.
          if (w_can_rd) begin
            w_rdreq     = 1'b1;
            w_state_nxt = S_HDR_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_inflight   <= 1'b0;
      r_if_data    <= 1'b0;
      r_if_sop     <= 1'b0;
      r_if_eop     <= 1'b0;
      r_words_left <= '0;
      r_last_mod   <= 3'd0;
      r_first      <= 1'b0;
      hdr_err      <= 1'b0;
      frm_cnt      <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_armed    <= 1'b1;
      r_inflight <= w_rdreq;
      r_if_data  <= w_data_rd;
      r_if_sop   <= r_first;
      r_if_eop   <= (r_words_left == c_WL_W'(1));
      hdr_err    <= w_hdr_drop;
      if (w_hdr_load) begin
        r_words_left <= w_len_sum[LEN_W:3];
        r_last_mod   <= w_len[2:0];
        r_first      <= 1'b1;
      end else if (w_data_rd) begin
        r_words_left <= r_words_left - c_WL_W'(1);
        r_first      <= 1'b0;
      end
      if (w_eop_pop) begin
        frm_cnt <= frm_cnt + 32'd1;
      end
    end
  end

  // Two-entry buffer, entry 0 is the head. The head only changes on a pop
  // or when the buffer is empty, so stalled outputs hold stable.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_occ  <= 2'd0;
      r_ent0 <= '0;
      r_ent1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_ent0 <= w_new;
          else               r_ent1 <= w_new;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_ent0 <= w_new;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rdreq = w_rdreq;
  assign bus.tx_val     = (r_occ != 2'd0);
  assign bus.tx_data    = r_ent0[c_EW-1:5];
  assign bus.tx_sop     = r_ent0[4];
  assign bus.tx_eop     = r_ent0[3];
  assign bus.tx_mod     = r_ent0[2:0];

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_fifo_frame_reader
// Description : Self-checking bench for tx_fifo_frame_reader. A queue-based
//               FIFO model feeds frames; a scoreboard of expected words is
//               built directly from each frame's byte length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_fifo_frame_reader;
  localparam int WIDTH   = 64;
  localparam int MAX_LEN = 9600;
  localparam int LEN_W   = 14;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        hdr_err;
  logic [31:0] frm_cnt;

  tx_fifo_frame_reader_if #(.WIDTH(WIDTH)) bus();

  tx_fifo_frame_reader #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_  (reset_),
    .bus     (bus),
    .hdr_err (hdr_err),
    .frm_cnt (frm_cnt)
  );

  always #5 clk = ~clk;

  logic [63:0] fifo_mem[$];
  logic [63:0] pending[$];
  logic [66:0] exp_q[$];
  int tests = 0, fails = 0;
  int pop_cnt = 0, overread = 0, err_seen = 0, gap_cnt = 0, acc_cnt = 0;
  int cyc = 0, last_acc = -10, rdy_mode = 0, feed_all = 1, pat = 0;
  int exp_err = 0, exp_frames = 0;
  logic        prev_stall = 1'b0;
  logic [66:0] prev_word = '0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO model: data appears on fifo_q the cycle after the pop request.
  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      bus.fifo_q <= '0;
    end else if (bus.fifo_rdreq) begin
      pop_cnt++;
      if (fifo_mem.size() == 0) overread++;
      else bus.fifo_q <= fifo_mem.pop_front();
    end
  end

  // Drive inputs and monitor outputs mid-cycle.
  always @(negedge clk) begin
    logic [66:0] got;
    logic [66:0] e;
    cyc++;
    if (feed_all != 0) begin
      while (pending.size() != 0) fifo_mem.push_back(pending.pop_front());
    end else if (pending.size() != 0 && $urandom_range(0, 2) == 0) begin
      fifo_mem.push_back(pending.pop_front());
    end
    bus.fifo_rdempty = (fifo_mem.size() == 0);
    case (rdy_mode)
      0: bus.tx_rdy = 1'b1;
      1: begin bus.tx_rdy = (pat == 0 || pat == 3); pat = (pat + 1) % 4; end
      default: bus.tx_rdy = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (reset_) begin
      got = {bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_mod};
      if (hdr_err) err_seen++;
      check_eq("buf_overflow", {127'd0, (dut.r_if_data && dut.r_occ == 2'd2 &&
                               !(bus.tx_val && bus.tx_rdy))}, 128'd0);
      if (prev_stall) begin
        check_eq("hold_val", {127'd0, bus.tx_val}, 128'd1);
        check_eq("hold_word", {61'd0, got}, {61'd0, prev_word});
      end
      if (bus.tx_val && bus.tx_rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("word", {61'd0, got}, {61'd0, e});
        end
        if (!bus.tx_sop && cyc != last_acc + 1) gap_cnt++;
        last_acc = cyc;
        acc_cnt++;
      end
      prev_stall = bus.tx_val && !bus.tx_rdy;
      prev_word  = got;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_frame(input int len);
    logic [63:0] w;
    logic [2:0]  m;
    int nw;
    nw = (len + 7) / 8;
    w = {$urandom, $urandom};
    w[LEN_W-1:0] = len[LEN_W-1:0];
    pending.push_back(w);
    for (int i = 0; i < nw; i++) begin
      w = {$urandom, $urandom};
      pending.push_back(w);
      m = (i == nw - 1) ? 3'(len % 8) : 3'd0;
      exp_q.push_back({w, (i == 0), (i == nw - 1), m});
    end
    exp_frames++;
  endtask

  task automatic push_bad(input int len);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[LEN_W-1:0] = len[LEN_W-1:0];
    pending.push_back(w);
    exp_err++;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pending.size() != 0 || fifo_mem.size() != 0 ||
            bus.tx_val) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check_eq("timeout", 128'd0, 128'd1);
    repeat (6) @(negedge clk);
    #2;
  endtask

  task automatic check_totals(input string tag);
    check_eq({tag, "_frm_cnt"}, {96'd0, frm_cnt}, 128'(exp_frames));
    check_eq({tag, "_hdr_err"}, 128'(err_seen), 128'(exp_err));
  endtask

  initial begin
    int p0, n, a0;
    bus.tx_rdy = 1'b1;
    bus.fifo_rdempty = 1'b1;
    // Frame loaded while reset is held: no pop may happen during reset.
    push_frame(64);
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_rdreq", {127'd0, bus.fifo_rdreq}, 128'd0);
    check_eq("rst_val", {127'd0, bus.tx_val}, 128'd0);
    check_eq("rst_sop_eop_mod", {123'd0, bus.tx_sop, bus.tx_eop, bus.tx_mod}, 128'd0);
    check_eq("rst_data", {64'd0, bus.tx_data}, 128'd0);
    check_eq("rst_hdr_err", {127'd0, hdr_err}, 128'd0);
    check_eq("rst_frm_cnt", {96'd0, frm_cnt}, 128'd0);
    @(negedge clk);
    reset_ = 1'b1;

    // len=64, tx_rdy held: 8 back-to-back words, 9 pops.
    gap_cnt = 0;
    wait_done(500);
    check_totals("len64");
    check_eq("len64_gaps", 128'(gap_cnt), 128'd0);
    check_eq("len64_pops", 128'(pop_cnt), 128'd9);

    // Partial last word and single-word frame.
    push_frame(13);
    push_frame(5);
    wait_done(500);
    check_totals("len13_5");

    // Stalled stream: 1,0,0,1 ready pattern.
    rdy_mode = 1;
    pat = 0;
    p0 = pop_cnt;
    push_frame(64);
    wait_done(500);
    check_totals("stall");
    check_eq("stall_pops", 128'(pop_cnt - p0), 128'd9);
    rdy_mode = 0;

    // Illegal headers then a good frame.
    push_bad(0);
    push_bad(MAX_LEN + 1);
    push_frame(16);
    wait_done(500);
    check_totals("bad_hdr");

    // Three back-to-back 16-byte frames, pre-filled.
    gap_cnt = 0;
    push_frame(16);
    push_frame(16);
    push_frame(16);
    wait_done(500);
    check_totals("b2b");
    check_eq("b2b_gaps", 128'(gap_cnt), 128'd0);

    // Randomized traffic with trickle feed and random backpressure.
    rdy_mode = 2;
    feed_all = 0;
    push_frame(1);
    push_frame(8);
    push_frame(9);
    push_frame(MAX_LEN);
    push_bad(MAX_LEN + 1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) push_bad(0);
        else push_bad(int'($urandom_range(MAX_LEN + 1, (1 << LEN_W) - 1)));
      end else begin
        push_frame(int'($urandom_range(1, 120)));
      end
    end
    wait_done(40000);
    check_totals("random");

    // Reset after 3 of 8 words accepted.
    rdy_mode = 0;
    feed_all = 1;
    a0 = acc_cnt;
    push_frame(64);
    n = 0;
    while (acc_cnt < a0 + 3 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 200) check_eq("mid_rst_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    reset_ = 1'b0;
    #1;
    check_eq("mid_rst_val", {127'd0, bus.tx_val}, 128'd0);
    check_eq("mid_rst_rdreq", {127'd0, bus.fifo_rdreq}, 128'd0);
    check_eq("mid_rst_framing", {123'd0, bus.tx_sop, bus.tx_eop, bus.tx_mod}, 128'd0);
    check_eq("mid_rst_data", {64'd0, bus.tx_data}, 128'd0);
    check_eq("mid_rst_frm_cnt", {96'd0, frm_cnt}, 128'd0);
    pending.delete();
    fifo_mem.delete();
    exp_q.delete();
    exp_frames = 0;
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    push_frame(16);
    wait_done(500);
    check_totals("after_rst");

    check_eq("fifo_overread", 128'(overread), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
